// File: rtl/csa_resolver.sv
// Carry-save to binary resolver: sum_o = ps_i + 2*sc_i, computed CHUNK bits per cycle
// through a single carry register so wide words close timing.
module csa_resolver #(
   parameter int LEN   = 256,
   parameter int CHUNK = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [LEN-1:0] ps_i,
   input  logic [LEN-1:0] sc_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [LEN+1:0] sum_o,
   output logic           busy_o
);

   localparam int NCHUNK = LEN / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((LEN % CHUNK) != 0) begin : g_bad_chunk
      $error("csa_resolver: LEN must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q;
   logic [LEN-1:0]   a_q, b_q, sum_lo_q;
   logic [1:0]       sum_hi_q;
   logic             top_q, carry_q;
   logic [CW-1:0]    cnt_q;
   logic [CHUNK:0]   add;
   logic             last;

   // Operands shift right each RUN cycle, so the active chunk is always at the bottom.
   always_comb begin
      add  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
      last = (cnt_q == CW'(NCHUNK - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sum_lo_q <= '0;
         sum_hi_q <= '0;
         top_q    <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid_i) begin
               a_q     <= ps_i;
               b_q     <= {sc_i[LEN-2:0], 1'b0};
               top_q   <= sc_i[LEN-1];
               carry_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               a_q      <= a_q >> CHUNK;
               b_q      <= b_q >> CHUNK;
               // Result chunks enter at the top; after NCHUNK cycles chunk 0 sits at bit 0.
               sum_lo_q <= (sum_lo_q >> CHUNK) | (LEN'(add[CHUNK-1:0]) << (LEN - CHUNK));
               carry_q  <= add[CHUNK];
               if (last) begin
                  sum_hi_q <= {1'b0, add[CHUNK]} + {1'b0, top_q};
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: if (out_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign sum_o       = {sum_hi_q, sum_lo_q};

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed and random checks on LEN=8/CHUNK=4, a wide
// LEN=256/CHUNK=64 instance fed through a CSA step, and a single-chunk LEN=CHUNK=8 instance.
module tb_csa_resolver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: LEN=8, CHUNK=4
   logic       a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_busy;
   logic [7:0] a_ps = '0, a_sc = '0;
   logic [9:0] a_sum;
   csa_resolver #(.LEN(8), .CHUNK(4)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid_i(a_iv), .in_ready_o(a_ir), .ps_i(a_ps), .sc_i(a_sc),
      .out_valid_o(a_ov), .out_ready_i(a_or), .sum_o(a_sum), .busy_o(a_busy));

   // instance B: LEN=256, CHUNK=64
   logic         b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_busy;
   logic [255:0] b_ps = '0, b_sc = '0;
   logic [257:0] b_sum;
   csa_resolver #(.LEN(256), .CHUNK(64)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid_i(b_iv), .in_ready_o(b_ir), .ps_i(b_ps), .sc_i(b_sc),
      .out_valid_o(b_ov), .out_ready_i(b_or), .sum_o(b_sum), .busy_o(b_busy));

   // instance C: LEN=CHUNK=8
   logic       c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0, c_busy;
   logic [7:0] c_ps = '0, c_sc = '0;
   logic [9:0] c_sum;
   csa_resolver #(.LEN(8), .CHUNK(8)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid_i(c_iv), .in_ready_o(c_ir), .ps_i(c_ps), .sc_i(c_sc),
      .out_valid_o(c_ov), .out_ready_i(c_or), .sum_o(c_sum), .busy_o(c_busy));

   task automatic chk(input string tag, input logic [257:0] got, input logic [257:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction on instance A, checking latency, value and hold under stall.
   task automatic run_a(input logic [7:0] ps, input logic [7:0] sc, input int stall);
      int n;
      logic [9:0] exp;
      exp = 10'(ps) + (10'(sc) << 1);
      n = 0;
      while (!a_ir && n < 50) begin tick(); n++; end
      chk("a_ready", 258'(a_ir), 258'(1));
      a_iv = 1'b1; a_ps = ps; a_sc = sc;
      tick();
      a_iv = 1'b0; a_ps = 8'($urandom); a_sc = 8'($urandom);
      n = 0;
      while (!a_ov && n < 50) begin tick(); n++; end
      chk("a_latency", 258'(n), 258'(2));
      chk("a_sum", 258'(a_sum), 258'(exp));
      repeat (stall) tick();
      chk("a_hold", 258'({a_ov, a_sum}), 258'({1'b1, exp}));
      a_or = 1'b1;
      tick();
      a_or = 1'b0;
      chk("a_release", 258'({a_ov, a_ir}), 258'(2'b01));
   endtask

   task automatic run_c(input logic [7:0] ps, input logic [7:0] sc);
      int n;
      logic [9:0] exp;
      exp = 10'(ps) + (10'(sc) << 1);
      c_iv = 1'b1; c_ps = ps; c_sc = sc;
      tick();
      c_iv = 1'b0;
      n = 0;
      while (!c_ov && n < 50) begin tick(); n++; end
      chk("c_latency", 258'(n), 258'(1));
      chk("c_sum", 258'(c_sum), 258'(exp));
      c_or = 1'b1;
      tick();
      c_or = 1'b0;
   endtask

   initial begin
      logic [9:0]   e;
      logic [255:0] ra, rb, rc;
      logic [257:0] q[$];
      logic [257:0] want;
      logic         ir_now;
      int           got, cyc, last_t, n;
      localparam int NOPS = 100;

      // reset values, observed while reset is asserted
      #12;
      chk("rst_a", 258'({a_ir, a_ov, a_busy, a_sum}), 258'({3'b100, 10'h0}));
      chk("rst_b", 258'({b_ir, b_ov, b_busy}), 258'(3'b100));
      chk("rst_b_sum", b_sum, '0);
      chk("rst_c", 258'({c_ir, c_ov, c_busy, c_sum}), 258'({3'b100, 10'h0}));
      #3 rst_n = 1'b1;
      tick();

      run_a(8'hFF, 8'hFF, 0);
      chk("a_2fd", 258'(a_sum), 258'(10'h2FD));
      run_a(8'h00, 8'h80, 1);
      chk("a_top", 258'(a_sum), 258'(10'h100));
      run_a(8'h0F, 8'h08, 0);
      chk("a_chunkc", 258'(a_sum), 258'(10'h01F));

      // stall in DONE for 5 cycles; a stray in_valid pulse must be ignored
      a_iv = 1'b1; a_ps = 8'h3C; a_sc = 8'h5A;
      tick();
      a_iv = 1'b0;
      e = 10'h3C + 10'h0B4;
      n = 0;
      while (!a_ov && n < 50) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin a_iv = 1'b1; a_ps = 8'h11; a_sc = 8'h22; end
         tick();
         a_iv = 1'b0;
         chk("stall", 258'({a_ov, a_ir, a_busy, a_sum}), 258'({3'b101, e}));
      end
      a_or = 1'b1;
      tick();
      a_or = 1'b0;
      chk("stall_idle", 258'({a_ov, a_ir}), 258'(2'b01));
      tick();
      chk("no_accept", 258'({a_busy, a_sum}), 258'({1'b0, e}));

      // asynchronous abort after the first RUN edge
      a_iv = 1'b1; a_ps = 8'hFF; a_sc = 8'hFF;
      tick();
      a_iv = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("abort", 258'({a_ov, a_ir, a_busy, a_sum}), 258'({3'b010, 10'h0}));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_a(8'h01, 8'h01, 0);
      chk("post_abort", 258'(a_sum), 258'(10'h003));

      for (int i = 0; i < 30; i++)
         run_a(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

      // single-chunk instance
      run_c(8'hAA, 8'h55);
      chk("c_154", 258'(c_sum), 258'(10'h154));
      for (int i = 0; i < 10; i++) run_c(8'($urandom), 8'($urandom));

      // wide instance: three random words through a CSA step, back-to-back
      for (int w = 0; w < 8; w++) begin
         ra = {ra[223:0], 32'($urandom)};
         rb = {rb[223:0], 32'($urandom)};
         rc = {rc[223:0], 32'($urandom)};
      end
      b_ps = ra ^ rb ^ rc;
      b_sc = (ra & rb) | (ra & rc) | (rb & rc);
      want = 258'(ra) + 258'(rb) + 258'(rc);
      b_iv = 1'b1; b_or = 1'b1;
      got = 0; cyc = 0; last_t = -1;
      while (got < NOPS && cyc < NOPS * 6 + 50) begin
         ir_now = b_ir;
         tick();
         cyc++;
         if (ir_now) begin
            q.push_back(want);
            for (int w = 0; w < 8; w++) begin
               ra = {ra[223:0], 32'($urandom)};
               rb = {rb[223:0], 32'($urandom)};
               rc = {rc[223:0], 32'($urandom)};
            end
            b_ps = ra ^ rb ^ rc;
            b_sc = (ra & rb) | (ra & rc) | (rb & rc);
            want = 258'(ra) + 258'(rb) + 258'(rc);
         end
         if (b_ov) begin
            if (q.size() == 0) chk("b_unexpected", 258'(1), 258'(0));
            else chk("b_sum", b_sum, q.pop_front());
            if (last_t >= 0) chk("b_period", 258'(cyc - last_t), 258'(6));
            last_t = cyc;
            got++;
         end
      end
      b_iv = 1'b0; b_or = 1'b0;
      chk("b_count", 258'(got), 258'(NOPS));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
